// File: rtl/parity_check_pipe_pkg.sv
// Shared definitions for the ALU result link: alarm FSM states, control-code
// widths and the opcode numbering shared with the encoder and ALU.
package parity_check_pipe_pkg;

    localparam int CTRL_W   = 3;
    localparam int FNCODE_W = 8;

    typedef enum logic [1:0] {
        S_OK    = 2'd0,
        S_ERR   = 2'd1,
        S_ALARM = 2'd2
    } state_e;

    localparam logic [CTRL_W-1:0] ADD  = 3'd0;
    localparam logic [CTRL_W-1:0] SUB  = 3'd1;
    localparam logic [CTRL_W-1:0] AND  = 3'd2;
    localparam logic [CTRL_W-1:0] OR   = 3'd3;
    localparam logic [CTRL_W-1:0] XOR  = 3'd4;
    localparam logic [CTRL_W-1:0] NAND = 3'd5;
    localparam logic [CTRL_W-1:0] NOR  = 3'd6;
    localparam logic [CTRL_W-1:0] XNOR = 3'd7;

endpackage

// File: rtl/parity_check_pipe_ctrl_decoder.sv
// 3-to-8 one-hot decoder turning an encoded control code back into the
// function code; inverse of the link-side encoder.
module ctrl_decoder
    import parity_check_pipe_pkg::*;
(
    input  logic [CTRL_W-1:0]   i_ctrl,
    output logic [FNCODE_W-1:0] o_fncode
);

    // One-hot decode, one entry per opcode.
    always_comb begin
        o_fncode = 8'b0000_0000;
        case (i_ctrl)
            ADD:     o_fncode = 8'b0000_0001;
            SUB:     o_fncode = 8'b0000_0010;
            AND:     o_fncode = 8'b0000_0100;
            OR:      o_fncode = 8'b0000_1000;
            XOR:     o_fncode = 8'b0001_0000;
            NAND:    o_fncode = 8'b0010_0000;
            NOR:     o_fncode = 8'b0100_0000;
            XNOR:    o_fncode = 8'b1000_0000;
            default: o_fncode = 8'b0000_0000;
        endcase
    end

endmodule

// File: rtl/parity_check_pipe.sv
// Two-stage receive pipeline: checks even parity on each result beat, decodes
// the control code, and keeps error statistics plus a consecutive-error alarm.
module parity_check_pipe
    import parity_check_pipe_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_parity,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic                err_clr,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [FNCODE_W-1:0] out_fncode,
    output logic                out_err,
    output logic [CNT_W-1:0]    err_count,
    output logic                sticky_err,
    output logic                alarm
);

    localparam logic [3:0]       LIMIT_C = 4'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic f_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    logic                r_s1_valid;
    logic [DATA_W-1:0]   r_s1_data;
    logic                r_s1_parity;
    logic [CTRL_W-1:0]   r_s1_ctrl;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [FNCODE_W-1:0] r_out_fncode;
    logic                r_out_err;
    logic [CNT_W-1:0]    r_err_count;
    logic                r_sticky_err;
    logic [3:0]          r_consec;
    state_e              r_state;

    logic                w_perr;
    logic                w_err_beat;
    logic [FNCODE_W-1:0] w_fncode;
    logic [3:0]          w_consec_inc;
    state_e              w_state_nxt;

    ctrl_decoder u_ctrl_decoder (
        .i_ctrl   (r_s1_ctrl),
        .o_fncode (w_fncode)
    );

    assign w_perr       = f_parity(r_s1_data) ^ r_s1_parity;
    assign w_err_beat   = r_s1_valid & w_perr;
    assign w_consec_inc = (r_consec >= LIMIT_C) ? LIMIT_C : (r_consec + 4'd1);

    // Stage 1: unconditional capture of the incoming beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_parity <= 1'b0;
            r_s1_ctrl   <= '0;
        end else begin
            r_s1_valid  <= in_valid;
            r_s1_data   <= in_data;
            r_s1_parity <= in_parity;
            r_s1_ctrl   <= in_ctrl;
        end
    end

    // Stage 2: data and decode hold their last value across invalid cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_fncode <= '0;
            r_out_err    <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_err   <= w_err_beat;
            if (r_s1_valid) begin
                r_out_data   <= r_s1_data;
                r_out_fncode <= w_fncode;
            end else begin
                r_out_data   <= r_out_data;
                r_out_fncode <= r_out_fncode;
            end
        end
    end

    // Alarm FSM next state, judged on valid beats; S_ALARM only leaves via err_clr.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_OK: begin
                if (w_err_beat) begin
                    w_state_nxt = (w_consec_inc >= LIMIT_C) ? S_ALARM : S_ERR;
                end else begin
                    w_state_nxt = S_OK;
                end
            end
            S_ERR: begin
                if (w_err_beat) begin
                    w_state_nxt = (w_consec_inc >= LIMIT_C) ? S_ALARM : S_ERR;
                end else if (r_s1_valid) begin
                    w_state_nxt = S_OK;
                end else begin
                    w_state_nxt = S_ERR;
                end
            end
            S_ALARM: w_state_nxt = S_ALARM;
            default: w_state_nxt = S_OK;
        endcase
    end

    // Statistics and FSM state; err_clr wins over a beat evaluated in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_count  <= '0;
            r_sticky_err <= 1'b0;
            r_consec     <= 4'd0;
            r_state      <= S_OK;
        end else if (err_clr) begin
            r_err_count  <= '0;
            r_sticky_err <= 1'b0;
            r_consec     <= 4'd0;
            r_state      <= S_OK;
        end else if (r_s1_valid) begin
            r_state <= w_state_nxt;
            if (w_perr) begin
                r_err_count  <= (r_err_count == CNT_MAX) ? r_err_count : (r_err_count + 1'b1);
                r_sticky_err <= 1'b1;
                r_consec     <= w_consec_inc;
            end else begin
                r_err_count  <= r_err_count;
                r_sticky_err <= r_sticky_err;
                r_consec     <= 4'd0;
            end
        end else begin
            r_err_count  <= r_err_count;
            r_sticky_err <= r_sticky_err;
            r_consec     <= r_consec;
            r_state      <= r_state;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_fncode = r_out_fncode;
    assign out_err    = r_out_err;
    assign err_count  = r_err_count;
    assign sticky_err = r_sticky_err;
    assign alarm      = (r_state == S_ALARM);

endmodule

// File: tb/tb_parity_check_pipe.sv
// Directed and random bench for parity_check_pipe, checked against a beat-level
// model of the receive rules (two instances: default counter and 2-bit counter).
module tb_parity_check_pipe;

    localparam int LIM = 3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_parity;
    logic [2:0] in_ctrl;
    logic       err_clr;

    logic       out_valid,   s_out_valid;
    logic [3:0] out_data,    s_out_data;
    logic [7:0] out_fncode,  s_out_fncode;
    logic       out_err,     s_out_err;
    logic [7:0] err_count;
    logic [1:0] s_err_count;
    logic       sticky_err,  s_sticky_err;
    logic       alarm,       s_alarm;

    int n_total = 0;
    int n_bad   = 0;

    // previous-cycle beat (what the pipeline has taken in) and expected outputs
    logic       p_valid, p_parity;
    logic [3:0] p_data;
    logic [2:0] p_ctrl;
    logic       e_valid, e_err, e_sticky, e_alarm;
    logic [3:0] e_data;
    logic [7:0] e_fn;
    int         e_cnt, e_run;

    parity_check_pipe #(.DATA_W(4), .CNT_W(8), .ERR_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_parity(in_parity), .in_ctrl(in_ctrl), .err_clr(err_clr),
        .out_valid(out_valid), .out_data(out_data), .out_fncode(out_fncode),
        .out_err(out_err), .err_count(err_count), .sticky_err(sticky_err), .alarm(alarm)
    );

    parity_check_pipe #(.DATA_W(4), .CNT_W(2), .ERR_LIMIT(LIM)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_parity(in_parity), .in_ctrl(in_ctrl), .err_clr(err_clr),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_fncode(s_out_fncode),
        .out_err(s_out_err), .err_count(s_err_count), .sticky_err(s_sticky_err), .alarm(s_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic p,
                         input logic [2:0] c, input logic clr, input logic rn);
        logic       bad_beat;
        logic [7:0] one8;
        one8 = 8'd1;
        @(negedge clk);
        in_valid = v; in_data = d; in_parity = p; in_ctrl = c; err_clr = clr; rst_n = rn;
        if (!rn) begin
            e_valid = 1'b0; e_err = 1'b0; e_sticky = 1'b0; e_alarm = 1'b0;
            e_data = 4'd0; e_fn = 8'd0; e_cnt = 0; e_run = 0;
            p_valid = 1'b0; p_data = 4'd0; p_parity = 1'b0; p_ctrl = 3'd0;
        end else begin
            bad_beat = p_valid && (($countones(p_data) % 2) != int'(p_parity));
            e_valid  = p_valid;
            e_err    = bad_beat;
            if (p_valid) begin
                e_data = p_data;
                e_fn   = one8 << p_ctrl;
            end
            if (clr) begin
                e_cnt = 0; e_run = 0; e_sticky = 1'b0; e_alarm = 1'b0;
            end else if (p_valid) begin
                if (bad_beat) begin
                    e_cnt++; e_run++; e_sticky = 1'b1;
                    if (e_run >= LIM) e_alarm = 1'b1;
                end else begin
                    e_run = 0;
                end
            end
            p_valid = v; p_data = d; p_parity = p; p_ctrl = c;
        end
        @(posedge clk);
        #1;
        chk("out_valid",  32'(out_valid),  32'(e_valid));
        chk("out_err",    32'(out_err),    32'(e_err));
        chk("out_data",   32'(out_data),   32'(e_data));
        chk("out_fncode", 32'(out_fncode), 32'(e_fn));
        chk("err_count",  32'(err_count),  32'((e_cnt > 255) ? 255 : e_cnt));
        chk("sticky_err", 32'(sticky_err), 32'(e_sticky));
        chk("alarm",      32'(alarm),      32'(e_alarm));
        chk("sat_count",  32'(s_err_count), 32'((e_cnt > 3) ? 3 : e_cnt));
    endtask

    initial begin
        logic [3:0] rd;
        logic       rp;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; in_parity = 1'b0;
        in_ctrl = 3'd0; err_clr = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);

        // clean beat
        drive(1'b1, 4'b1111, 1'b0, 3'b001, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_fn",    32'(out_fncode), 32'h02);
        chk("t1_err",   32'(out_err), 32'd0);

        // single error then good beat
        drive(1'b1, 4'b0101, 1'b1, 3'b111, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("t2_err", 32'(out_err), 32'd1);
        chk("t2_fn",  32'(out_fncode), 32'h80);
        chk("t2_cnt", 32'(err_count), 32'd1);
        drive(1'b1, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1);
        chk("t2_sticky", 32'(sticky_err), 32'd0);

        // alarm after three error beats with an idle gap before the third
        drive(1'b1, 4'b0001, 1'b0, 3'd2, 1'b0, 1'b1);
        drive(1'b1, 4'b0011, 1'b1, 3'd3, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("t3_no_alarm", 32'(alarm), 32'd0);
        drive(1'b1, 4'b0111, 1'b0, 3'd4, 1'b0, 1'b1);
        drive(1'b1, 4'b0110, 1'b0, 3'd5, 1'b0, 1'b1);
        chk("t3_alarm", 32'(alarm), 32'd1);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("t3_alarm_hold", 32'(alarm), 32'd1);
        chk("t3_cnt", 32'(err_count), 32'd3);

        // err_clr colliding with an error beat in stage 2
        drive(1'b1, 4'b1000, 1'b0, 3'd6, 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b1);
        chk("t4_err",    32'(out_err), 32'd1);
        chk("t4_cnt",    32'(err_count), 32'd0);
        chk("t4_sticky", 32'(sticky_err), 32'd0);
        chk("t4_alarm",  32'(alarm), 32'd0);

        // saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) drive(1'b1, 4'b0001, 1'b0, 3'(i), 1'b0, 1'b1);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("t5_sat", 32'(s_err_count), 32'd3);
        chk("t5_cnt", 32'(err_count), 32'd5);

        // reset with beats in flight
        drive(1'b1, 4'b1010, 1'b0, 3'd1, 1'b0, 1'b1);
        drive(1'b1, 4'b1011, 1'b0, 3'd2, 1'b0, 1'b1);
        drive(1'b1, 4'b1100, 1'b0, 3'd3, 1'b0, 1'b0);
        chk("t6_valid0", 32'(out_valid), 32'd0);
        chk("t6_data0",  32'(out_data), 32'd0);
        drive(1'b1, 4'b1101, 1'b1, 3'd4, 1'b0, 1'b1);
        chk("t6_flush", 32'(out_valid), 32'd0);
        drive(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_data",  32'(out_data), 32'hD);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rd = 4'($urandom_range(0, 15));
            rp = (^rd) ^ (($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
            drive(1'($urandom_range(0, 3) != 0), rd, rp, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 79) != 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/parity_check_pipe.md
Name: parity_check_pipe

Overview:
- Receive-side counterpart of the ALU result path: it accepts each result nibble with its even-parity bit and the 3-bit control code.
- It checks parity, decodes the control code back to the one-hot 8-bit function code, and tracks error statistics.
- It is a 2-stage pipeline with a small alarm FSM, and sits downstream of the parity generator at the consumer end of the link.

Parameters:
- DATA_W, 4: width of the result word that is checked.
- CNT_W, 8: width of the saturating total-error counter.
- ERR_LIMIT, 3: number of consecutive parity-error beats that raises alarm (legal range 1..15).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- in_valid  input  1  beat qualifier for in_data, in_parity and in_ctrl.
- in_data  input  DATA_W  result word.
- in_parity  input  1  transmitted parity bit, equal to the XOR of all in_data bits.
- in_ctrl  input  3  encoded function code (000..111).
- err_clr  input  1  single-cycle pulse that clears err_count, sticky_err and the FSM.
- out_valid  output  1  beat qualifier for the out_* outputs.
- out_data  output  DATA_W  in_data, delayed 2 cycles.
- out_fncode  output  8  one-hot decode of in_ctrl (1 << in_ctrl).
- out_err  output  1  parity mismatch on this beat.
- err_count  output  CNT_W  total error beats, saturating.
- sticky_err  output  1  set on any error beat, held until err_clr.
- alarm  output  1  high while the FSM is in S_ALARM.

Behaviour:
- Reset (rst_n=0 at posedge) sets every output and internal register to 0, with FSM = S_OK.
- Reset mid-stream drops in-flight beats; out_valid is 0 on the first cycle after reset deasserts.
- Stage 1 registers in_valid, in_data, in_parity and in_ctrl every cycle without a handshake; invalid beats carry don't-care data.
- Stage 2 computes perr = (^s1_data) ^ s1_parity.
  - It registers out_valid = s1_valid, out_data, out_fncode = 8'b1 << s1_ctrl, and out_err = s1_valid & perr.
- Latency is fixed at 2 cycles from in_valid to out_valid. Throughput is 1 beat per cycle, with no backpressure.
- When out_valid=0, out_err is 0; out_data and out_fncode hold their last values.
- Statistics update on the cycle that stage 2 evaluates a valid beat, so they change in the same cycle out_valid rises.
  - err_count: +1 per error beat; it saturates at 2**CNT_W-1 with no wrap.
  - sticky_err: set by an error beat.
  - consec counter (4-bit, internal): +1 per error beat, reset to 0 by a good beat; it saturates at ERR_LIMIT.
- FSM transitions are evaluated only on valid beats, except err_clr:
  - S_OK: an error beat goes to S_ERR, or to S_ALARM if ERR_LIMIT=1.
  - S_ERR: a good beat goes to S_OK; an error beat that brings consec to ERR_LIMIT goes to S_ALARM; otherwise stay.
  - S_ALARM: good and error beats do not leave this state; only err_clr exits it.
- err_clr: on the next edge, err_count, sticky_err and consec become 0 and the FSM goes to S_OK.
  - err_clr has priority over a same-cycle valid beat. That beat is still output with its correct out_err, but it is not counted.
- rst_n has priority over err_clr.
- Invalid cycles between beats do not break a consecutive-error run.

Decomposition:
- Shared package holds:
  - the FSM state enum (S_OK, S_ERR, S_ALARM, 2-bit);
  - CTRL_W=3 and FNCODE_W=8 constants;
  - opcode localparams (ADD=0 .. XNOR=7), shared with the encoder and ALU.
- One sub-module, ctrl_decoder (3-to-8 one-hot, combinational). It is the inverse of the existing encoder and is reusable by other pipeline stages.

Test Plan:
1. Clean beat: reset, then in_data=4'b1111, in_parity=0, in_ctrl=3'b001 -> 2 cycles later out_valid=1, out_fncode=8'b0000_0010, out_err=0, err_count=0, alarm=0.
2. Single error: in_data=4'b0101, in_parity=1, in_ctrl=3'b111 -> out_err=1, out_fncode=8'b1000_0000, err_count=1, sticky_err=1, FSM=S_ERR. A following good beat returns the FSM to S_OK while sticky_err stays 1.
3. Alarm: 3 back-to-back error beats (ERR_LIMIT=3), with 2 idle cycles inserted between the 2nd and 3rd beats -> alarm=1 in the cycle the 3rd beat's out_valid=1. A later good beat leaves alarm=1, and err_count=3.
4. Clear collision: err_clr pulsed in the same cycle stage 2 evaluates an error beat -> out_err=1 for that beat; afterwards err_count=0, sticky_err=0, alarm=0.
5. Saturation: with CNT_W=2, send 5 error beats -> err_count sticks at 3.
6. Reset mid-stream: send beats on consecutive cycles and assert rst_n=0 for 1 cycle while 2 beats are in flight -> those beats never appear, all outputs are 0, and the next beat emerges with 2-cycle latency.
